// File: rtl/mfda_seq_pkg.sv
// Shared definitions for the mixer dosing sequencer.
//   state_t   : sequencer phase encoding
//   N_CH_DEF  : default number of reagent inlet channels
//   DUR_W_DEF : default width of every duration field (cycles)
package mfda_seq_pkg;

    localparam int unsigned N_CH_DEF  = 4;
    localparam int unsigned DUR_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOSE,
        S_GAP,
        S_MIX,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_timer.sv
// Phase down-counter shared by every timed phase of the sequencer.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the counter with value (phase entry)
//   value    : phase length in cycles
//   expire   : high in the last cycle of the phase (count == 1)
module seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Counting stops at zero so an idle counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/mix_sequencer.sv
// Microfluidic mixer sequencer: doses eligible reagent channels in ascending
// order with a one-cycle break-before-make gap, then mixes, flushes and
// pulses done. Abort in DOSE/GAP/MIX jumps straight to the flush.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : sequence control
//   ch_mask       : channels taking part
//   dose_dur      : per-channel dose time, slice i = [i*DUR_W +: DUR_W]
//   mix_dur       : mix valve hold time
//   flush_dur     : flush valve hold time
//   valve_open    : reagent inlet drives (zero- or one-hot)
//   mix_valve, flush_valve : mixer / waste valve drives
//   busy, done, aborted    : status
module mix_sequencer
    import mfda_seq_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [N_CH*DUR_W-1:0] dose_dur,
    input  logic [DUR_W-1:0]      mix_dur,
    input  logic [DUR_W-1:0]      flush_dur,
    output logic [N_CH-1:0]       valve_open,
    output logic                  mix_valve,
    output logic                  flush_valve,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDX_W = CH_W + 1;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [N_CH*DUR_W-1:0]   dose_q, dose_d;
    logic [DUR_W-1:0]        mix_q, mix_d;
    logic [DUR_W-1:0]        flush_q, flush_d;
    logic                    aborted_q, aborted_d;
    logic [N_CH-1:0]         valve_q, valve_d;
    logic                    mix_valve_q, mix_valve_d;
    logic                    flush_valve_q, flush_valve_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    tmr_load;
    logic [DUR_W-1:0]        tmr_value;
    logic                    tmr_expire;

    logic [IDX_W-1:0]        search_from;
    logic [IDX_W-1:0]        nxt_idx;
    logic [DUR_W-1:0]        nxt_dur;
    logic                    nxt_found;
    logic                    seek;
    logic                    to_flush;

    seq_timer #(.W(DUR_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    // Configuration is captured only when a start is accepted.
    always_comb begin
        mask_d  = mask_q;
        dose_d  = dose_q;
        mix_d   = mix_q;
        flush_d = flush_q;
        if (state_q == S_IDLE && start) begin
            mask_d  = ch_mask;
            dose_d  = dose_dur;
            mix_d   = mix_dur;
            flush_d = flush_dur;
        end
    end

    // Lowest eligible channel at or above search_from; N_CH means none left.
    assign search_from = (state_q == S_IDLE) ? '0 : (IDX_W'(ch_q) + IDX_W'(1));

    always_comb begin
        nxt_idx = IDX_W'(N_CH);
        nxt_dur = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (IDX_W'(i) >= search_from && mask_d[i] &&
                dose_d[i*DUR_W +: DUR_W] != '0) begin
                nxt_idx = IDX_W'(i);
                nxt_dur = dose_d[i*DUR_W +: DUR_W];
            end
        end
    end

    assign nxt_found = (nxt_idx < IDX_W'(N_CH));

    // Next state; seek picks the next dose or falls through to mix, and
    // to_flush enters flush or skips to done when flush time is zero.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        aborted_d = aborted_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        seek      = 1'b0;
        to_flush  = 1'b0;

        if (abort && (state_q == S_DOSE || state_q == S_GAP || state_q == S_MIX)) begin
            aborted_d = 1'b1;
            to_flush  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        aborted_d = 1'b0;
                        seek      = 1'b1;
                    end
                end
                S_DOSE:  if (tmr_expire) state_d = S_GAP;
                S_GAP:   seek = 1'b1;
                S_MIX:   if (tmr_expire) to_flush = 1'b1;
                S_FLUSH: if (tmr_expire) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (seek) begin
            if (nxt_found) begin
                state_d   = S_DOSE;
                ch_d      = nxt_idx[CH_W-1:0];
                tmr_load  = 1'b1;
                tmr_value = nxt_dur;
            end else if (mix_d != '0) begin
                state_d   = S_MIX;
                tmr_load  = 1'b1;
                tmr_value = mix_d;
            end else begin
                to_flush = 1'b1;
            end
        end

        if (to_flush) begin
            if (flush_d != '0) begin
                state_d   = S_FLUSH;
                tmr_load  = 1'b1;
                tmr_value = flush_d;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // Outputs decoded from the next state so they line up with it once registered.
    always_comb begin
        valve_d       = (state_d == S_DOSE) ? (N_CH'(1) << ch_d) : '0;
        mix_valve_d   = (state_d == S_MIX);
        flush_valve_d = (state_d == S_FLUSH);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            mask_q        <= '0;
            dose_q        <= '0;
            mix_q         <= '0;
            flush_q       <= '0;
            aborted_q     <= 1'b0;
            valve_q       <= '0;
            mix_valve_q   <= 1'b0;
            flush_valve_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            mask_q        <= mask_d;
            dose_q        <= dose_d;
            mix_q         <= mix_d;
            flush_q       <= flush_d;
            aborted_q     <= aborted_d;
            valve_q       <= valve_d;
            mix_valve_q   <= mix_valve_d;
            flush_valve_q <= flush_valve_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign valve_open  = valve_q;
    assign mix_valve   = mix_valve_q;
    assign flush_valve = flush_valve_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Self-checking bench for mix_sequencer (N_CH=3, DUR_W=8): directed table,
// reset/restart sequence and randomized runs against a phase-list model.
module tb_mix_sequencer;

    localparam int unsigned NC = 3;
    localparam int unsigned DW = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [NC-1:0]     ch_mask;
    logic [NC*DW-1:0]  dose_dur;
    logic [DW-1:0]     mix_dur;
    logic [DW-1:0]     flush_dur;
    logic [NC-1:0]     valve_open;
    logic              mix_valve;
    logic              flush_valve;
    logic              busy;
    logic              done;
    logic              aborted;

    mix_sequencer #(.N_CH(NC), .DUR_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .ch_mask     (ch_mask),
        .dose_dur    (dose_dur),
        .mix_dur     (mix_dur),
        .flush_dur   (flush_dur),
        .valve_open  (valve_open),
        .mix_valve   (mix_valve),
        .flush_valve (flush_valve),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tot_cnt;
    int pass_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packed observation: {valve_open[2:0], mix, flush, busy, done, aborted}
    function automatic logic [7:0] obs();
        return {valve_open, mix_valve, flush_valve, busy, done, aborted};
    endfunction

    // Expected per-cycle outputs for cycles 1..L after start (L = done cycle).
    logic [7:0] exp_q[$];
    int         ph_q[$];   // 0 dose, 1 gap, 2 mix, 3 flush, 4 done

    task automatic build_model(input logic [2:0] m, input int d0, input int d1, input int d2,
                               input int mx, input int fl, input int ab_cyc,
                               output logic fab);
        int d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        exp_q.delete();
        ph_q.delete();
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch] && d[ch] != 0) begin
                for (int k = 0; k < d[ch]; k++) begin
                    exp_q.push_back({3'(1 << ch), 5'b00100}); ph_q.push_back(0);
                end
                exp_q.push_back(8'b000_00100); ph_q.push_back(1);
            end
        end
        for (int k = 0; k < mx; k++) begin exp_q.push_back(8'b000_10100); ph_q.push_back(2); end
        for (int k = 0; k < fl; k++) begin exp_q.push_back(8'b000_01100); ph_q.push_back(3); end
        exp_q.push_back(8'b000_00110); ph_q.push_back(4);
        fab = 1'b0;
        if (ab_cyc >= 1 && ab_cyc <= exp_q.size()) begin
            if (ph_q[ab_cyc-1] <= 2) begin
                fab = 1'b1;
                while (exp_q.size() > ab_cyc) begin
                    void'(exp_q.pop_back());
                    void'(ph_q.pop_back());
                end
                for (int k = 0; k < fl; k++) begin exp_q.push_back(8'b000_01101); ph_q.push_back(3); end
                exp_q.push_back(8'b000_00111); ph_q.push_back(4);
            end
        end
    endtask

    task automatic run_seq(input logic [2:0] m, input int d0, input int d1, input int d2,
                           input int mx, input int fl, input int ab_cyc,
                           input int sx1, input int sx2, input bit scramble,
                           output int done_cyc, output logic ab_at_done, output int valve_cyc);
        logic       fab;
        logic [2:0] prev_v;
        int         ndone;
        int         len;
        build_model(m, d0, d1, d2, mx, fl, ab_cyc, fab);
        len = exp_q.size();
        @(posedge clk); #1;
        ch_mask   = m;
        dose_dur  = {8'(d2), 8'(d1), 8'(d0)};
        mix_dur   = 8'(mx);
        flush_dur = 8'(fl);
        start     = 1'b1;
        abort     = (ab_cyc == 0);
        done_cyc = -1; ab_at_done = 1'b0; valve_cyc = 0; ndone = 0; prev_v = '0;
        for (int c = 1; c <= len + 3; c++) begin
            @(posedge clk); #1;
            start = (c == sx1) || (c == sx2);
            abort = (c == ab_cyc);
            if (scramble) begin
                ch_mask   = 3'($urandom);
                dose_dur  = 24'($urandom);
                mix_dur   = 8'($urandom);
                flush_dur = 8'($urandom);
            end
            @(negedge clk);
            if (c <= len) chk($sformatf("cyc%0d", c), obs(), exp_q[c-1]);
            else          chk($sformatf("idle%0d", c), obs(), {7'b0, fab});
            chk("onehot", $onehot0(valve_open), 1);
            chk("gap", (valve_open != 0 && prev_v != 0 && valve_open != prev_v), 0);
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin done_cyc = c; ab_at_done = aborted; end
            end
            if (valve_open != 0) valve_cyc++;
            prev_v = valve_open;
        end
        chk("done_count", ndone, 1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        logic [2:0] m;
        int d0, d1, d2, mx, fl, ab, sx1, sx2;
        int   e_done;
        logic e_ab;
        int   e_valve;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int   dc;
        logic abd;
        int   vc;
        bit   seen;

        tot_cnt = 0; pass_cnt = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ch_mask = '0; dose_dur = '0; mix_dur = '0; flush_dur = '0;

        //          mask    d0 d1 d2 mx fl  ab sx1 sx2 done ab valve
        tbl[0]  = '{3'b101, 4, 9, 2, 3, 2, -1, -1, -1, 14, 1'b0, 6};
        tbl[1]  = '{3'b000, 5, 5, 5, 2, 1, -1, -1, -1,  4, 1'b0, 0};
        tbl[2]  = '{3'b101, 4, 9, 2, 3, 2,  3, -1, -1,  6, 1'b1, 3};
        tbl[3]  = '{3'b101, 4, 9, 2, 3, 2,  5, -1, -1,  8, 1'b1, 4};
        tbl[4]  = '{3'b101, 4, 9, 2, 3, 2, 10, -1, -1, 13, 1'b1, 6};
        tbl[5]  = '{3'b101, 4, 9, 2, 3, 2, 12, -1, -1, 14, 1'b0, 6};
        tbl[6]  = '{3'b101, 4, 9, 2, 3, 2, -1,  5, 14, 14, 1'b0, 6};
        tbl[7]  = '{3'b111, 0, 0, 0, 0, 0, -1, -1, -1,  1, 1'b0, 0};
        tbl[8]  = '{3'b001, 1, 0, 0, 4, 0,  3, -1, -1,  4, 1'b1, 1};
        tbl[9]  = '{3'b101, 4, 9, 2, 3, 2,  0, -1, -1, 14, 1'b0, 6};
        tbl[10] = '{3'b110, 7, 1, 3, 1, 1, -1, -1, -1,  9, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", obs(), 8'h00);

        for (int i = 0; i < 11; i++) begin
            run_seq(tbl[i].m, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].mx, tbl[i].fl,
                    tbl[i].ab, tbl[i].sx1, tbl[i].sx2, 1'b1, dc, abd, vc);
            chk($sformatf("t%0d_done_cycle", i), dc, tbl[i].e_done);
            chk($sformatf("t%0d_aborted", i), abd, tbl[i].e_ab);
            chk($sformatf("t%0d_valve_cycles", i), vc, tbl[i].e_valve);
        end

        // Reset mid-sequence at cycle 7, restart at cycle 9.
        @(posedge clk); #1;
        ch_mask = 3'b101; dose_dur = {8'd2, 8'd9, 8'd4}; mix_dur = 8'd3; flush_dur = 8'd2;
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 7) rst = 1'b1;
            if (c == 7) begin
                @(negedge clk);
                chk("pre_rst_valve2", valve_open, 3'b100);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clear", obs(), 8'h00);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("restart_valve0", {valve_open, busy}, 4'b0011);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("restart_done", seen, 1'b1);
        @(posedge clk);

        // Randomized configurations, aborts and input churn.
        for (int r = 0; r < 40; r++) begin
            logic [2:0] m;
            int a;
            m = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
            run_seq(m, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), a, -1, -1, 1'b1, dc, abd, vc);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/mix_sequencer.md
MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of reagent inlet valves dosed into the mixer.
REQ-002 Parameter DUR_W, default 8: width of every duration field, in clock cycles.
REQ-003 clk  input  1  single clock; every state element updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begins a sequence; honoured only in IDLE.
REQ-006 abort  input  1  cuts a running sequence short.
REQ-007 ch_mask  input  N_CH  set bit i = channel i takes part in the sequence.
REQ-008 dose_dur  input  N_CH*DUR_W  dose time of channel i; slice i is bits [i*DUR_W +: DUR_W].
REQ-009 mix_dur  input  DUR_W  mix valve hold time.
REQ-010 flush_dur  input  DUR_W  flush valve hold time.
REQ-011 valve_open  output  N_CH  reagent inlet valve drives; at most one bit set at any time.
REQ-012 mix_valve  output  1  mixer isolation valve drive.
REQ-013 flush_valve  output  1  flush/waste valve drive.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of each sequence.
REQ-016 aborted  output  1  status of the most recent sequence; valid while done=1 and held until the next start.

Function
REQ-017 States: IDLE, DOSE, GAP, MIX, FLUSH, DONE; all outputs are registered.
REQ-018 start=1 in IDLE latches ch_mask, dose_dur, mix_dur and flush_dur; input changes after that have no effect on the running sequence.
REQ-019 A channel is eligible when its mask bit is 1 and its dose_dur slice is non-zero; eligible channels are dosed in ascending index order.
REQ-020 DOSE on channel i holds valve_open[i]=1 for exactly dose_dur[i] cycles; the first DOSE cycle is the cycle after start is accepted.
REQ-021 Each DOSE is followed by exactly one GAP cycle with all outputs low except busy (break-before-make), and then the next eligible channel's DOSE or MIX.
REQ-022 With no eligible channel, the sequence goes IDLE -> MIX with no DOSE and no GAP.
REQ-023 MIX holds mix_valve=1 for mix_dur cycles; FLUSH holds flush_valve=1 for flush_dur cycles; a zero duration skips that phase in zero cycles.
REQ-024 DONE lasts one cycle with done=1, then the state returns to IDLE; a start in the DONE cycle is ignored.
REQ-025 abort=1 in DOSE, GAP or MIX closes all valves in the next cycle and enters FLUSH (or DONE if flush_dur=0), and sets aborted=1.
REQ-026 abort in FLUSH, DONE or IDLE is ignored; when start and abort are both high in IDLE, start wins and abort is ignored.
REQ-027 Phase timing uses one down-counter of DUR_W bits, loaded when a phase is entered and leaving the phase when it reaches 1; no wrap-around is possible.

Reset
REQ-028 rst=1 forces state IDLE and clears all outputs, the counter and the latched configuration in the next cycle, including mid-sequence.
REQ-029 rst takes priority over start and abort.

Structure
REQ-030 Package mfda_seq_pkg holds the state enum and the default DUR_W and N_CH constants.
REQ-031 The counter is one sub-module, seq_timer (load, value, expire), instantiated once.
REQ-032 The next-eligible-channel search is combinational over the latched mask and durations.

Verification
REQ-033 N_CH=3, mask=101, dose={2,x,4}, mix=3, flush=2, start at cycle 0 -> valve0 high cycles 1-4, GAP 5, valve2 high 6-7, GAP 8, mix_valve high 9-11, flush_valve high 12-13, done at 14, busy high 1-14, aborted=0.
REQ-034 mask=000, mix=2, flush=1, start at cycle 0 -> mix_valve high 1-2, flush_valve high 3, done at 4, no valve_open activity.
REQ-035 Same setup as REQ-033 with abort at cycle 3 -> all valves low at 4, flush_valve high 4-5, done at 6, aborted=1.
REQ-036 rst asserted at cycle 7 of REQ-033 -> all outputs low from cycle 8, state IDLE; a new start is accepted at cycle 9.
REQ-037 start pulsed at cycles 5 and 14 during REQ-033 -> both ignored, timeline unchanged, no second sequence begins.
REQ-038 Random masks and durations -> valve_open always zero- or one-hot, a GAP cycle between every two DOSEs, exactly one done per accepted start.
